// File: rtl/loteria_pkg.sv
// rtl/loteria_pkg.sv - shared types and widths for the Loteria controller and core
package loteria_pkg;

  localparam int NUM_W    = 4;
  localparam int PREMIO_W = 2;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ARB,
    ST_INSERT,
    ST_DRAIN,
    ST_CLOSE,
    ST_WAIT,
    ST_CAPTURE,
    ST_END,
    ST_DONE
  } ctrl_state_t;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_P1   = 2'd1;
  localparam logic [1:0] OWN_P2   = 2'd2;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin arbiter with last-grant register
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       enable_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  // Set when requester 1 (player 2) was granted last; reset gives player 1 priority.
  logic last_q;

  always_comb begin
    gnt_o = 2'b00;
    if (enable_i) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
        default: gnt_o = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= 1'b1;
    end else if (enable_i && (gnt_o != 2'b00)) begin
      last_q <= gnt_o[1];
    end
  end

endmodule

// File: rtl/loteria_ctrl.sv
// rtl/loteria_ctrl.sv - two-player bet sequencer and arbiter in front of the Loteria core
module loteria_ctrl
  import loteria_pkg::*;
#(
  parameter int DIGITS  = 5,
  parameter int BETS    = 2,
  parameter int RES_LAT = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                req1,
  input  logic                req2,
  input  logic [NUM_W-1:0]    num1,
  input  logic [NUM_W-1:0]    num2,
  output logic                gnt1,
  output logic                gnt2,
  output logic                insere,
  output logic [NUM_W-1:0]    numero,
  output logic                fim,
  output logic                fim_jogo,
  input  logic [PREMIO_W-1:0] premio,
  output logic [PREMIO_W-1:0] premio_p1,
  output logic [PREMIO_W-1:0] premio_p2,
  output logic [1:0]          owner,
  output logic                busy,
  output logic                done
);

  localparam int DW = $clog2(DIGITS + 1);
  localparam int WW = $clog2(RES_LAT + 1);
  localparam int BW = $clog2(BETS + 1);

  localparam logic [DW-1:0] DIG_LAST  = DW'(DIGITS - 1);
  localparam logic [WW-1:0] WAIT_INIT = WW'(RES_LAT);
  localparam logic [WW-1:0] WAIT_ONE  = WW'(1);
  localparam logic [BW-1:0] BET_LAST  = BW'(BETS - 1);

  ctrl_state_t         state_q, state_d;
  logic [1:0]          owner_q, owner_d;
  logic [DW-1:0]       dig_cnt_q, dig_cnt_d;
  logic [WW-1:0]       wait_cnt_q, wait_cnt_d;
  logic [BW-1:0]       bet_cnt_q, bet_cnt_d;
  logic [PREMIO_W-1:0] premio_p1_q, premio_p1_d;
  logic [PREMIO_W-1:0] premio_p2_q, premio_p2_d;
  logic                insere_q, insere_d;
  logic [NUM_W-1:0]    numero_q, numero_d;

  logic [1:0]          arb_gnt;
  logic                owner_req;
  logic [NUM_W-1:0]    owner_num;

  rr_arb2 u_arb (
    .clk_i    (clock),
    .rst_ni   (reset),
    .enable_i (state_q == ST_ARB),
    .req_i    ({req2, req1}),
    .gnt_o    (arb_gnt)
  );

  always_comb begin
    owner_req = 1'b0;
    owner_num = '0;
    if (owner_q == OWN_P1) begin
      owner_req = req1;
      owner_num = num1;
    end else if (owner_q == OWN_P2) begin
      owner_req = req2;
      owner_num = num2;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    dig_cnt_d   = dig_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    bet_cnt_d   = bet_cnt_q;
    premio_p1_d = premio_p1_q;
    premio_p2_d = premio_p2_q;
    insere_d    = 1'b0;
    numero_d    = '0;
    gnt1        = 1'b0;
    gnt2        = 1'b0;
    fim         = 1'b0;
    fim_jogo    = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_ARB;
          premio_p1_d = '0;
          premio_p2_d = '0;
          bet_cnt_d   = '0;
        end
      end
      ST_ARB: begin
        dig_cnt_d = '0;
        if (arb_gnt[0]) begin
          owner_d = OWN_P1;
          state_d = ST_INSERT;
        end else if (arb_gnt[1]) begin
          owner_d = OWN_P2;
          state_d = ST_INSERT;
        end
      end
      ST_INSERT: begin
        // Only the owner's request is honoured; it may pause for any length.
        if (owner_req) begin
          gnt1     = (owner_q == OWN_P1);
          gnt2     = (owner_q == OWN_P2);
          insere_d = 1'b1;
          numero_d = owner_num;
          if (dig_cnt_q == DIG_LAST) begin
            dig_cnt_d = '0;
            state_d   = ST_DRAIN;
          end else begin
            dig_cnt_d = dig_cnt_q + 1'b1;
          end
        end
      end
      ST_DRAIN: state_d = ST_CLOSE;
      ST_CLOSE: begin
        fim        = 1'b1;
        wait_cnt_d = WAIT_INIT;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_cnt_q <= WAIT_ONE) begin
          state_d = ST_CAPTURE;
        end else begin
          wait_cnt_d = wait_cnt_q - 1'b1;
        end
      end
      ST_CAPTURE: begin
        if (owner_q == OWN_P1) premio_p1_d = premio;
        if (owner_q == OWN_P2) premio_p2_d = premio;
        bet_cnt_d = bet_cnt_q + 1'b1;
        owner_d   = OWN_NONE;
        state_d   = (bet_cnt_q == BET_LAST) ? ST_END : ST_ARB;
      end
      ST_END: begin
        fim_jogo = 1'b1;
        state_d  = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_NONE;
      dig_cnt_q   <= '0;
      wait_cnt_q  <= '0;
      bet_cnt_q   <= '0;
      premio_p1_q <= '0;
      premio_p2_q <= '0;
      insere_q    <= 1'b0;
      numero_q    <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      dig_cnt_q   <= dig_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      bet_cnt_q   <= bet_cnt_d;
      premio_p1_q <= premio_p1_d;
      premio_p2_q <= premio_p2_d;
      insere_q    <= insere_d;
      numero_q    <= numero_d;
    end
  end

  assign insere    = insere_q;
  assign numero    = numero_q;
  assign premio_p1 = premio_p1_q;
  assign premio_p2 = premio_p2_q;
  assign owner     = owner_q;
  assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_loteria_ctrl.sv
// tb/tb_loteria_ctrl.sv - self-checking bench for loteria_ctrl
module tb_loteria_ctrl;
  import loteria_pkg::*;

  localparam int DIGITS  = 5;
  localparam int BETS    = 2;
  localparam int RES_LAT = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       req1 = 1'b0, req2 = 1'b0;
  logic [3:0] num1 = '0, num2 = '0;
  logic       gnt1, gnt2, insere, fim, fim_jogo, busy, done;
  logic [3:0] numero;
  logic [1:0] premio = '0;
  logic [1:0] premio_p1, premio_p2, owner;

  int checks = 0;
  int errors = 0;
  logic [3:0] sbq[$];
  logic [1:0] exp_p1, exp_p2;

  typedef struct {
    logic        r1;
    logic        r2;
    logic [19:0] d1;
    logic [19:0] d2;
    logic [1:0]  pv;
    logic [1:0]  own;
    int          gap;
    logic        start_mid;
  } bet_vec_t;

  bet_vec_t vec[8];

  loteria_ctrl #(.DIGITS(DIGITS), .BETS(BETS), .RES_LAT(RES_LAT)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .req1      (req1),
    .req2      (req2),
    .num1      (num1),
    .num2      (num2),
    .gnt1      (gnt1),
    .gnt2      (gnt2),
    .insere    (insere),
    .numero    (numero),
    .fim       (fim),
    .fim_jogo  (fim_jogo),
    .premio    (premio),
    .premio_p1 (premio_p1),
    .premio_p2 (premio_p2),
    .owner     (owner),
    .busy      (busy),
    .done      (done)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (got running, need finished)");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [19:0] digs(input int a, input int b, input int c, input int d, input int e);
    return {4'(e), 4'(d), 4'(c), 4'(b), 4'(a)};
  endfunction

  // Scoreboard on the core side: every insere strobe must carry the next queued digit.
  always @(negedge clock) begin
    if (insere) begin
      if (sbq.size() == 0) begin
        chk("insere_unexpected", 1, 0);
      end else begin
        chk("numero", numero, sbq.pop_front());
      end
    end else begin
      chk("numero_idle_zero", numero, 0);
    end
    if (insere && fim) chk("insere_fim_overlap", 1, 0);
  end

  task automatic set_req(input logic [1:0] p, input logic v);
    if (p == OWN_P1) req1 = v; else req2 = v;
  endtask

  task automatic set_num(input logic [1:0] p, input logic [3:0] v);
    if (p == OWN_P1) num1 = v; else num2 = v;
  endtask

  task automatic pulse_start();
    @(posedge clock); #1;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    @(negedge clock);
  endtask

  task automatic run_bet(input bet_vec_t v, input bit last);
    logic [19:0] dg;
    bit found;
    found = 0;
    dg = (v.own == OWN_P1) ? v.d1 : v.d2;
    req1 = v.r1;
    req2 = v.r2;
    num1 = v.d1[3:0];
    num2 = v.d2[3:0];
    premio = v.pv;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clock);
      if (owner != OWN_NONE) found = 1;
      else begin @(posedge clock); #1; end
    end
    chk("arb_owner", owner, v.own);
    if (!found) begin
      req1 = 0; req2 = 0;
      return;
    end
    for (int i = 0; i < DIGITS; i++) begin
      chk("gnt_owner", (v.own == OWN_P1) ? gnt1 : gnt2, 1);
      chk("gnt_other", (v.own == OWN_P1) ? gnt2 : gnt1, 0);
      sbq.push_back(dg[4*i +: 4]);
      @(posedge clock); #1;
      start = 1'b0;
      if (i == DIGITS - 1) begin
        req1 = 0; req2 = 0;
      end else begin
        if (i + 1 == v.gap) begin
          set_req(v.own, 1'b0);
          repeat (7) begin
            @(negedge clock);
            chk("gap_gnt", {gnt1, gnt2}, 0);
            chk("gap_state", dut.state_q, ST_INSERT);
            chk("gap_dig_cnt", 32'(dut.dig_cnt_q), v.gap);
            chk("gap_fim", fim, 0);
            @(posedge clock); #1;
          end
          set_req(v.own, 1'b1);
        end
        set_num(v.own, dg[4*(i+1) +: 4]);
        if (v.start_mid && i == 1) start = 1'b1;
        @(negedge clock);
      end
    end
    @(negedge clock);
    chk("drain_insere", insere, 1);
    chk("drain_fim", fim, 0);
    @(negedge clock);
    chk("close_fim", fim, 1);
    repeat (RES_LAT) begin
      @(negedge clock);
      chk("wait_fim", fim, 0);
    end
    @(negedge clock);
    if (v.own == OWN_P1) exp_p1 = v.pv; else exp_p2 = v.pv;
    @(negedge clock);
    chk("premio_p1", premio_p1, exp_p1);
    chk("premio_p2", premio_p2, exp_p2);
    chk("owner_released", owner, OWN_NONE);
    chk("fim_jogo", fim_jogo, last);
    if (last) begin
      @(negedge clock);
      chk("done", done, 1);
      chk("fim_jogo_once", fim_jogo, 0);
    end
  endtask

  task automatic run_game(input int a, input int b);
    pulse_start();
    exp_p1 = '0;
    exp_p2 = '0;
    chk("start_clr_p1", premio_p1, 0);
    chk("start_clr_p2", premio_p2, 0);
    chk("start_busy", busy, 1);
    chk("start_done", done, 0);
    run_bet(vec[a], 0);
    run_bet(vec[b], 1);
  endtask

  initial begin
    vec[0] = '{1, 0, digs(5, 3, 8, 2, 0), digs(1, 1, 1, 1, 1), 2'b10, OWN_P1, -1, 0};
    vec[1] = '{1, 1, digs(1, 2, 3, 4, 5), digs(9, 8, 7, 6, 5), 2'b01, OWN_P2, -1, 0};
    vec[2] = '{1, 1, digs(15, 0, 14, 1, 13), digs(4, 4, 2, 2, 6), 2'b11, OWN_P1, 2, 0};
    vec[3] = '{1, 1, digs(2, 2, 2, 2, 2), digs(10, 11, 12, 13, 3), 2'b00, OWN_P2, -1, 1};
    vec[4] = '{0, 1, digs(0, 0, 0, 0, 0), digs(6, 7, 8, 9, 1), 2'b10, OWN_P2, -1, 0};
    vec[5] = '{0, 1, digs(0, 0, 0, 0, 0), digs(3, 1, 4, 1, 5), 2'b11, OWN_P2, -1, 1};
    vec[6] = '{1, 1, digs(8, 6, 7, 5, 3), digs(0, 9, 0, 9, 0), 2'b01, OWN_P1, -1, 0};
    vec[7] = '{1, 1, digs(1, 1, 2, 2, 3), digs(12, 4, 12, 4, 7), 2'b10, OWN_P2, -1, 0};

    repeat (3) @(negedge clock);
    chk("reset_outs", {gnt1, gnt2, insere, numero, fim, fim_jogo, premio_p1, premio_p2, owner, busy, done}, 0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);

    run_game(0, 1);
    run_game(2, 3);
    run_game(4, 5);

    // Reset asserted in WAIT abandons the bet without fim_jogo.
    pulse_start();
    req1 = 1'b1;
    num1 = 4'd7;
    for (int k = 0; k < 20 && owner == OWN_NONE; k++) @(negedge clock);
    chk("rst_seq_owner", owner, OWN_P1);
    for (int i = 0; i < DIGITS; i++) begin
      sbq.push_back(4'd7);
      @(posedge clock); #1;
      if (i == DIGITS - 1) req1 = 1'b0;
      else @(negedge clock);
    end
    @(negedge clock);
    @(negedge clock);
    chk("rst_seq_fim", fim, 1);
    @(negedge clock);
    chk("rst_seq_state", dut.state_q, ST_WAIT);
    #1 reset = 1'b0;
    #1;
    chk("async_reset_outs", {gnt1, gnt2, insere, numero, fim, fim_jogo, premio_p1, premio_p2, owner, busy, done}, 0);
    repeat (3) begin
      @(negedge clock);
      chk("in_reset_quiet", {fim, fim_jogo, busy}, 0);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    run_game(6, 7);

    chk("scoreboard_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/loteria_ctrl.md
# loteria_ctrl

Game sequencer and arbiter in front of the Loteria core. It shares the core's single number-entry port between two players. It grants whole bets round-robin, forwards each player's digits to the core, and closes each bet with `fim`. It then captures the resulting `premio` per player and ends the game with `fim_jogo` after a fixed number of bets.

## Interface

Parameters:
- `DIGITS`, default 5: numbers per bet.
- `BETS`, default 2: bets per game, summed over both players.
- `RES_LAT`, default 2: cycles from the `fim` pulse to a valid `premio` from the core.

Ports:
- `clock`, in, 1: single clock. All logic is on the rising edge.
- `reset`, in, 1: asynchronous, active-low. All state clears immediately on assertion.
- `start`, in, 1: begin a game. Sampled only in IDLE or DONE.
- `req1`, `req2`, in, 1: the player has a digit valid on `num1`/`num2`.
- `num1`, `num2`, in, 4: digit value.
- `gnt1`, `gnt2`, out, 1: the digit was accepted this cycle. Combinational.
- `insere`, out, 1: to the core. Registered one-cycle strobe per digit.
- `numero`, out, 4: to the core. Registered. Equals 0 whenever `insere` is 0.
- `fim`, out, 1: to the core. One-cycle bet-close pulse.
- `fim_jogo`, out, 1: to the core. One-cycle end-of-game pulse.
- `premio`, in, 2: from the core. Sampled only in CAPTURE.
- `premio_p1`, `premio_p2`, out, 2: last captured prize of each player.
- `owner`, out, 2: player owning the core. 0 = none, 1 = player 1, 2 = player 2.
- `busy`, out, 1: state is neither IDLE nor DONE.
- `done`, out, 1: high in DONE.

## Operation

States and transitions:
- IDLE → ARB when `start` = 1. Clears `premio_p1`, `premio_p2` and the bet counter.
- ARB: the first requester wins. If both request, the player not served last wins. After reset, "last" is player 2, so player 1 has priority.
  - The winner is latched in `owner` and the state goes to INSERT.
  - With no request, stay in ARB indefinitely.
- INSERT:
  - While `req` of `owner` is 1: `gnt` of owner = 1, the digit is registered into `numero`/`insere`, and the digit counter increments.
  - The non-owner's `req` is ignored and its `gnt` stays 0. The owner may idle between digits with no timeout.
  - Accepting digit `DIGITS` → DRAIN.
- DRAIN: one cycle in which the core sees the last `insere`. → CLOSE.
- CLOSE: `fim` = 1 for one cycle. → WAIT.
- WAIT: `RES_LAT` cycles, counted down. → CAPTURE.
- CAPTURE:
  - `premio` is written to the owner's `premio_pX`. The bet counter increments and `owner` becomes 0.
  - If the count equals `BETS`, → END. Otherwise → ARB.
- END: `fim_jogo` = 1 for one cycle. → DONE.
- DONE: `done` = 1 and the results are held. `start` → ARB, clearing the results exactly as from IDLE.

Rules:
- `start` is ignored in every state except IDLE and DONE.
- A player may win consecutive bets if the other player is not requesting.
- There is no per-player bet limit.
- Counter widths are `$clog2(DIGITS+1)`, `$clog2(RES_LAT+1)` and `$clog2(BETS+1)`. Counters never wrap within a game.

## Timing

- Reset values: state = IDLE, and every output = 0.
  - Asserting `reset` mid-bet abandons the bet with no `fim` pulse. Any core cleanup is the core's own reset's job.
- Digit latency: accept at cycle t gives `insere`/`numero` at t+1.
  - Back-to-back accepts are allowed, one digit per cycle.
- Last-digit accept at t gives:
  - DRAIN at t+1, with the last `insere` = 1.
  - `fim` at t+2.
  - CAPTURE at t+3+`RES_LAT`.
  - `premio_pX` updated at t+4+`RES_LAT`.
- `insere` and `fim` are never high in the same cycle.
- `fim_jogo` is high exactly one cycle, one cycle after the final CAPTURE.

## Structure

- Shared package `loteria_pkg`:
  - State enum `ctrl_state_t`.
  - Owner encodings `OWN_NONE`, `OWN_P1`, `OWN_P2`.
  - Width constants `NUM_W` = 4 and `PREMIO_W` = 2, shared with the Loteria core.
- Sub-module `rr_arb2`:
  - Two-requester round-robin with a last-grant register.
  - Has an `enable` input, driven high only in ARB.
  - Outputs a one-hot grant.
- All counters and the state register live in `loteria_ctrl`. The `numero`/`insere` output registers live there too.

## Test plan

- Reset, then `start`. Only `req1` is held, with digits 5, 3, 8, 2, 0 on consecutive cycles:
  - `gnt1` is high for 5 cycles and `insere` carries 5, 3, 8, 2, 0, each one cycle later.
  - `fim` pulses two cycles after the last accept.
  - With the core returning `premio` = 2'b10, `premio_p1` = 2'b10 at t+6.
- `req1` and `req2` both held in ARB right after reset:
  - Player 1 wins the first bet and player 2 the second.
  - `gnt2` stays 0 during player 1's bet.
  - `fim_jogo` pulses once after the second CAPTURE, then `done` = 1.
- The owner drops `req` for 7 cycles after digit 2:
  - The state stays INSERT, the digit count holds at 2, and no `fim` occurs.
  - The bet completes normally when `req` returns.
- `start` pulsed during INSERT: no effect. `start` in DONE: results are cleared to 0 and the state goes to ARB.
- `reset` driven low during WAIT: all outputs are 0 immediately, with no `fim_jogo`. The following `start` runs a full game normally.
